// File: rtl/complex_rd_pkg.sv
// complex_rd_pkg: shared types and helpers for the complex RAM read sequencer.
package complex_rd_pkg;
  localparam int LANES = 4;
  // Widest component supported by the lane() helper.
  localparam int MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rdState_e;

  // Slice lane i of a packed lane vector whose lanes are w bits wide.
  // The caller keeps the low w bits of the result.
  function automatic logic [MAX_W-1:0] lane(input logic [LANES*MAX_W-1:0] vec,
                                            input int i, input int w);
    return MAX_W'(vec >> (i*w));
  endfunction
endpackage

// File: rtl/complex_rd_fifo2.sv
// complex_rd_fifo2: two-entry FIFO that absorbs the registered RAM read latency.
module complex_rd_fifo2 #(
  parameter int W = 1
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   occupancy
);
  logic [1:0][W-1:0] mem;
  logic              wrPtr, rdPtr;
  logic              doPush, doPop;

  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign full   = (occupancy == 2'd2);
  assign empty  = (occupancy == 2'd0);
  assign rdata  = mem[rdPtr];

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem       <= '0;
      wrPtr     <= 1'b0;
      rdPtr     <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= wdata;
        wrPtr      <= ~wrPtr;
      end
      if (doPop) rdPtr <= ~rdPtr;
      case ({doPush, doPop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end
endmodule

// File: rtl/complex_ram_reader.sv
// complex_ram_reader: burst read sequencer for the four-lane complex RAM bank.
// Optional macro COMPLEX_RD_MAG_EN adds m_mag (per-lane |re|+|im|, saturating).
module complex_ram_reader
  import complex_rd_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH:0]     count,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   r_addr,
  input  logic [LANES*WIDTH-1:0]  ram_re,
  input  logic [LANES*WIDTH-1:0]  ram_im,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [LANES*WIDTH-1:0]  m_re,
  output logic [LANES*WIDTH-1:0]  m_im,
  output logic [ADDR_WIDTH-1:0]   m_idx,
  output logic                    m_last
`ifdef COMPLEX_RD_MAG_EN
  ,
  output logic [LANES*(WIDTH+1)-1:0] m_mag
`endif
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int DW = 2*LANES*WIDTH + ADDR_WIDTH + 1;

  rdState_e              state;
  logic [ADDR_WIDTH-1:0] addrQ, nextAddr;
  logic [CW-1:0]         remaining, clipCount;
  logic                  inFlight, flightLast;
  logic [ADDR_WIDTH-1:0] flightIdx;
  logic                  issue, pop;
  logic                  fifoFull, fifoEmpty;
  logic [1:0]            occ;
  logic [DW-1:0]         headData;

  assign clipCount = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;
  assign nextAddr  = (addrQ == ADDR_WIDTH'(DEPTH-1)) ? '0 : addrQ + 1'b1;
  assign pop       = m_valid && m_ready;
  // Issue only if the data it returns is guaranteed a buffer slot.
  assign issue     = (state == READ) && (remaining != '0) &&
                     ((3'(occ) + 3'(inFlight) - 3'(pop)) < 3'd2);

  assign r_addr  = addrQ;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign m_valid = !fifoEmpty;
  assign {m_re, m_im, m_idx, m_last} = headData;

  // Burst FSM with address and remaining-beat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addrQ     <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addrQ     <= base_addr;
          remaining <= clipCount;
          state     <= (clipCount == '0) ? DONE : READ;
        end
        READ: if (issue) begin
          addrQ     <= nextAddr;
          remaining <= remaining - 1'b1;
          if (remaining == CW'(1)) state <= DRAIN;
        end
        DRAIN: if (pop && m_last) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag of the read in flight; its data arrives on ram_re/ram_im next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inFlight   <= 1'b0;
      flightIdx  <= '0;
      flightLast <= 1'b0;
    end else begin
      inFlight <= issue;
      if (issue) begin
        flightIdx  <= addrQ;
        flightLast <= (remaining == CW'(1));
      end
    end
  end

  complex_rd_fifo2 #(.W(DW)) uBuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inFlight),
    .pop       (pop),
    .wdata     ({ram_re, ram_im, flightIdx, flightLast}),
    .rdata     (headData),
    .full      (fifoFull),
    .empty     (fifoEmpty),
    .occupancy (occ)
  );

`ifdef COMPLEX_RD_MAG_EN
  localparam int MW = WIDTH + 1;
  logic [LANES*MAX_W-1:0] reExt, imExt;
  assign reExt = (LANES*MAX_W)'(m_re);
  assign imExt = (LANES*MAX_W)'(m_im);

  for (genvar g = 0; g < LANES; g++) begin : gMag
    logic [MAX_W-1:0] reL, imL;
    logic [MW-1:0]    reX, imX, absRe, absIm;
    logic [MW:0]      sum;
    assign reL   = lane(reExt, g, WIDTH);
    assign imL   = lane(imExt, g, WIDTH);
    // Sign-extend one bit so the most-negative value's magnitude fits.
    assign reX   = {reL[WIDTH-1], reL[WIDTH-1:0]};
    assign imX   = {imL[WIDTH-1], imL[WIDTH-1:0]};
    assign absRe = reX[MW-1] ? (~reX + 1'b1) : reX;
    assign absIm = imX[MW-1] ? (~imX + 1'b1) : imX;
    assign sum   = {1'b0, absRe} + {1'b0, absIm};
    assign m_mag[g*MW +: MW] = sum[MW] ? {MW{1'b1}} : sum[MW-1:0];
  end
`endif

  logic unusedFull;
  assign unusedFull = fifoFull;
endmodule

// File: tb/tb_complex_ram_reader.sv
// tb_complex_ram_reader: randomized bursts checked against a queue-free
// address/data reference computed from base, count and the RAM contents.
module tb_complex_ram_reader;
  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk, rstN, start, busy, done, mValid, mReady, mLast;
  logic [AW-1:0] baseAddr, rAddr, mIdx;
  logic [AW:0]   count;
  logic [31:0]   ramRe, ramIm, mRe, mIm;
`ifdef COMPLEX_RD_MAG_EN
  logic [35:0]   mMag;
`endif

  logic [31:0] memRe [DEPTH];
  logic [31:0] memIm [DEPTH];
  int nTests = 0;
  int nFail  = 0;

  complex_ram_reader #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rstN), .start(start), .base_addr(baseAddr), .count(count),
    .busy(busy), .done(done), .r_addr(rAddr), .ram_re(ramRe), .ram_im(ramIm),
    .m_valid(mValid), .m_ready(mReady), .m_re(mRe), .m_im(mIm), .m_idx(mIdx),
    .m_last(mLast)
`ifdef COMPLEX_RD_MAG_EN
    , .m_mag(mMag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered RAM: outputs reflect the previous cycle's read address.
  always @(posedge clk) begin
    ramRe <= memRe[rAddr];
    ramIm <= memIm[rAddr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int refMag(input logic [7:0] re, input logic [7:0] im);
    int r, i, s;
    r = $signed(re);
    i = $signed(im);
    s = (r < 0 ? -r : r) + (i < 0 ? -i : i);
    return (s > 511) ? 511 : s;
  endfunction

  task automatic checkReset(input string tag);
    chk({tag, "_raddr"}, 64'(rAddr), 0);
    chk({tag, "_busy"},  64'(busy), 0);
    chk({tag, "_done"},  64'(done), 0);
    chk({tag, "_valid"}, 64'(mValid), 0);
    chk({tag, "_re"},    64'(mRe), 0);
    chk({tag, "_im"},    64'(mIm), 0);
    chk({tag, "_idx"},   64'(mIdx), 0);
    chk({tag, "_last"},  64'(mLast), 0);
  endtask

  // readyPct < 0: hold m_ready low for the first 5 valid cycles, then 1.
  task automatic runBurst(input int base, input int cnt, input int readyPct,
                          input bit poke, input bit forceMag);
    int n, beats, stallCnt, issued;
    bit lastHs, seenDone, prevStall;
    logic [31:0] pRe, pIm;
    logic [AW-1:0] pIdx;
    logic pLast;
    int e;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    for (int i = 0; i < DEPTH; i++) begin
      memRe[i] = $urandom;
      memIm[i] = $urandom;
    end
    if (forceMag) begin
      memRe[base][7:0] = 8'h80; memIm[base][7:0] = 8'h7F;
      memRe[(base+1)%DEPTH][7:0] = 8'hFD; memIm[(base+1)%DEPTH][7:0] = 8'h04;
    end
    @(negedge clk);
    baseAddr = AW'(base);
    count    = (AW+1)'(cnt);
    start    = 1'b1;
    mReady   = (readyPct < 0) ? 1'b0 : ($urandom_range(99) < readyPct);
    beats = 0; stallCnt = 0; lastHs = (n == 0); seenDone = 0; prevStall = 0;
    pRe = '0; pIm = '0; pIdx = '0; pLast = 1'b0;
    for (int cyc = 0; cyc < 100 && !seenDone; cyc++) begin
      @(negedge clk);
      start = poke ? 1'($urandom_range(1)) : 1'b0;
      if (poke) begin
        baseAddr = AW'($urandom);
        count    = (AW+1)'($urandom);
      end
      chk("busy", 64'(busy), 1);
      chk("done", 64'(done), 64'(lastHs));
      if (done === 1'b1) seenDone = 1;
      if (readyPct == 100 && cyc < n) chk("raddr_seq", 64'(rAddr), 64'((base + cyc) % DEPTH));
      issued = (int'(rAddr) - base + DEPTH) % DEPTH;
      if (issued >= beats) chk("outstanding_le2", 64'(issued <= beats + 2), 1);
      if (prevStall) begin
        chk("stall_valid", 64'(mValid), 1);
        chk("stall_idx",   64'(mIdx), 64'(pIdx));
        chk("stall_re",    64'(mRe), 64'(pRe));
        chk("stall_im",    64'(mIm), 64'(pIm));
        chk("stall_last",  64'(mLast), 64'(pLast));
      end
      if (readyPct < 0) begin
        if (stallCnt >= 5) mReady = 1'b1;
        else begin
          mReady = 1'b0;
          if (mValid) stallCnt++;
        end
      end else mReady = ($urandom_range(99) < readyPct);
      lastHs = 0;
      if (mValid && mReady) begin
        e = (base + beats) % DEPTH;
        chk("beat_idx",  64'(mIdx), 64'(e));
        chk("beat_re",   64'(mRe), 64'(memRe[e]));
        chk("beat_im",   64'(mIm), 64'(memIm[e]));
        chk("beat_last", 64'(mLast), 64'(beats == n - 1));
`ifdef COMPLEX_RD_MAG_EN
        for (int l = 0; l < 4; l++)
          chk("beat_mag", 64'(mMag[l*9 +: 9]), 64'(refMag(memRe[e][l*8 +: 8], memIm[e][l*8 +: 8])));
        if (forceMag && beats == 0) chk("mag_a_255", 64'(mMag[8:0]), 255);
        if (forceMag && beats == 1) chk("mag_a_7", 64'(mMag[8:0]), 7);
`endif
        if (beats == n - 1) lastHs = 1;
        beats++;
      end
      prevStall = mValid && !mReady;
      pRe = mRe; pIm = mIm; pIdx = mIdx; pLast = mLast;
    end
    start = 1'b0;
    chk("done_seen", 64'(seenDone), 1);
    chk("beat_count", 64'(beats), 64'(n));
    @(negedge clk);
    chk("idle_busy",  64'(busy), 0);
    chk("idle_done",  64'(done), 0);
    chk("idle_valid", 64'(mValid), 0);
  endtask

  task automatic midReset(input int base);
    int beats;
    for (int i = 0; i < DEPTH; i++) begin
      memRe[i] = $urandom;
      memIm[i] = $urandom;
    end
    @(negedge clk);
    baseAddr = AW'(base); count = 4'd6; start = 1'b1; mReady = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beats = 0;
    for (int cyc = 0; cyc < 50 && beats < 2; cyc++) begin
      if (mValid && mReady) beats++;
      @(negedge clk);
    end
    chk("rst_two_beats", 64'(beats), 2);
    rstN = 1'b0;
    #1;
    checkReset("midrst");
    @(negedge clk);
    rstN = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      chk("postrst_done",  64'(done), 0);
      chk("postrst_busy",  64'(busy), 0);
      chk("postrst_valid", 64'(mValid), 0);
    end
  endtask

  initial begin
    rstN = 1'b0; start = 1'b0; mReady = 1'b0; baseAddr = '0; count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      memRe[i] = '0;
      memIm[i] = '0;
    end
    repeat (2) @(negedge clk);
    checkReset("reset");
    rstN = 1'b1;
    runBurst(2, 4, 100, 0, 0);
    runBurst(6, 5, 100, 0, 0);
    runBurst(1, 4, -1, 0, 0);
    runBurst(3, 0, 100, 0, 0);
    runBurst(5, 15, 100, 0, 0);
    runBurst(0, 8, 60, 1, 0);
    midReset($urandom_range(7));
    runBurst(7, 3, 100, 0, 0);
    runBurst(4, 2, 100, 0, 1);
    for (int k = 0; k < 12; k++)
      runBurst($urandom_range(7), $urandom_range(15), $urandom_range(100, 30),
               1'($urandom_range(1)), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
